// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the pipelined ALU.
//   ALU_OP_W    - opcode width used by alu_op_e
//   alu_op_e    - opcode encoding; values 10..15 are illegal and yield a zero result
//   alu_state_e - top-level control states (IDLE, MUL)
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_SLL = 4'd4,
    OP_ROL = 4'd5,
    OP_SRL = 4'd6,
    OP_SRA = 4'd7,
    OP_XOR = 4'd8,
    OP_MUL = 4'd9
  } alu_op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: unsigned shift-add multiplier, one partial-product step per clock.
//   clk, rst_n  - clock, asynchronous active-low reset
//   start_i     - load operands and perform the first step on this edge
//   a_i, b_i    - multiplicand / multiplier, sampled when start_i is high
//   done_o      - all DATA_W steps complete; product_o is final this cycle
//   product_o   - 2*DATA_W-bit product {hi, lo}
// The first step is folded into the start edge so that done_o is high in the
// cycle just before edge start+DATA_W, letting the consumer register the
// product on exactly that edge.
module alu_mul_iter #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [DATA_W-1:0]     a_i,
  input  logic [DATA_W-1:0]     b_i,
  output logic                  done_o,
  output logic [2*DATA_W-1:0]   product_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W);

  logic [DATA_W-1:0]   a_q, a_d;
  logic [2*DATA_W-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                run_q, run_d;

  // One shift-add step: conditionally add A into the high half, then shift
  // the whole {carry, hi, lo} right by one; the multiplier drains out of lo.
  function automatic logic [2*DATA_W-1:0] mul_step(
    input logic [DATA_W-1:0] hi,
    input logic [DATA_W-1:0] lo,
    input logic [DATA_W-1:0] a
  );
    logic [DATA_W:0] sum;
    sum = {1'b0, hi} + (lo[0] ? {1'b0, a} : {(DATA_W+1){1'b0}});
    return {sum, lo[DATA_W-1:1]};
  endfunction

  // Step sequencing: start loads and performs step 1, then one step per cycle.
  always_comb begin
    a_d    = a_q;
    prod_d = prod_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    if (start_i) begin
      a_d    = a_i;
      prod_d = mul_step({DATA_W{1'b0}}, b_i, a_i);
      cnt_d  = {{(CNT_W-1){1'b0}}, 1'b1};
      run_d  = 1'b1;
    end else if (run_q && (cnt_q != LAST_STEP)) begin
      prod_d = mul_step(prod_q[2*DATA_W-1:DATA_W], prod_q[DATA_W-1:0], a_q);
      cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (run_q) begin
      run_d  = 1'b0;
    end else begin
      run_d  = 1'b0;
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= {DATA_W{1'b0}};
      prod_q <= {(2*DATA_W){1'b0}};
      cnt_q  <= {CNT_W{1'b0}};
      run_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      prod_q <= prod_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
    end
  end

  assign done_o    = run_q && (cnt_q == LAST_STEP);
  assign product_o = prod_q;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: single-issue ALU with a registered valid/ready output stage.
//   clk, rst_n        - clock, asynchronous active-low reset
//   in_valid/in_ready - request handshake (accepted when both high at posedge)
//   op, src1, src2    - opcode and operands (src2 low bits = shift amount)
//   out_valid/ready   - result handshake; outputs hold while stalled
//   alu_result        - registered result
//   overflow, zero    - registered flags
//   busy              - iterative multiply in progress
// Non-MUL ops complete in one cycle; MUL runs DATA_W cycles in alu_mul_iter.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = ALU_OP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_result,
  output logic              overflow,
  output logic              zero,
  output logic              busy
);

  localparam int SH_W = $clog2(DATA_W);
  localparam int MSB  = DATA_W - 1;

  alu_state_e          state_q, state_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                ovf_q, ovf_d;
  logic                zero_q, zero_d;

  logic [ALU_OP_W-1:0] op_s;
  logic [SH_W-1:0]     shamt_s;
  logic [2*DATA_W-1:0] rot_s;
  logic [DATA_W-1:0]   res_s;
  logic                ovf_s;
  logic                accept_s;
  logic                mul_start_s;
  logic                mul_done_s;
  logic [2*DATA_W-1:0] product_s;

  assign op_s        = op[ALU_OP_W-1:0];
  assign shamt_s     = src2[SH_W-1:0];
  assign in_ready    = (state_q == ST_IDLE) && (!valid_q || out_ready);
  assign accept_s    = in_valid && in_ready;
  assign mul_start_s = accept_s && (op_s == OP_MUL);

  alu_mul_iter #(.DATA_W(DATA_W)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (mul_start_s),
    .a_i       (src1),
    .b_i       (src2),
    .done_o    (mul_done_s),
    .product_o (product_s)
  );

  // Single-cycle datapath for every opcode except MUL.
  always_comb begin
    res_s = {DATA_W{1'b0}};
    ovf_s = 1'b0;
    // Rotate: shift a doubled copy so wrapped bits land in the upper half.
    rot_s = {src1, src1} << shamt_s;
    case (op_s)
      OP_ADD: begin
        res_s = src1 + src2;
        ovf_s = (src1[MSB] == src2[MSB]) && (res_s[MSB] != src1[MSB]);
      end
      OP_SUB: begin
        res_s = src1 - src2;
        ovf_s = (src1[MSB] != src2[MSB]) && (res_s[MSB] != src1[MSB]);
      end
      OP_AND:  res_s = src1 & src2;
      OP_OR:   res_s = src1 | src2;
      OP_XOR:  res_s = src1 ^ src2;
      OP_SLL:  res_s = src1 << shamt_s;
      OP_ROL:  res_s = rot_s[2*DATA_W-1:DATA_W];
      OP_SRL:  res_s = src1 >> shamt_s;
      OP_SRA:  res_s = DATA_W'($signed(src1) >>> shamt_s);
      default: begin
        res_s = {DATA_W{1'b0}};
        ovf_s = 1'b0;
      end
    endcase
  end

  // Control FSM and output-register next state.
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (mul_start_s) begin
          state_d = ST_MUL;
          valid_d = 1'b0;
        end else if (accept_s) begin
          valid_d  = 1'b1;
          result_d = res_s;
          ovf_d    = ovf_s;
          zero_d   = (res_s == {DATA_W{1'b0}});
        end else if (valid_q && out_ready) begin
          valid_d = 1'b0;
        end else begin
          valid_d = valid_q;
        end
      end
      ST_MUL: begin
        if (mul_done_s) begin
          state_d  = ST_IDLE;
          valid_d  = 1'b1;
          result_d = product_s[DATA_W-1:0];
          ovf_d    = |product_s[2*DATA_W-1:DATA_W];
          zero_d   = (product_s[DATA_W-1:0] == {DATA_W{1'b0}});
        end else begin
          state_d = ST_MUL;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      valid_q  <= 1'b0;
      result_q <= {DATA_W{1'b0}};
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign out_valid  = valid_q;
  assign alu_result = result_q;
  assign overflow   = ovf_q;
  assign zero       = zero_q;
  assign busy       = (state_q == ST_MUL);

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vectors for alu_pipe (DATA_W = 32) with a cycle-level
// reference model and hand-computed literal expectations.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'd0;
  logic [31:0] src1 = 32'd0;
  logic [31:0] src2 = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] alu_result;
  logic        overflow;
  logic        zero;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_pipe #(.DATA_W(32), .OP_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .src1       (src1),
    .src2       (src2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_result (alu_result),
    .overflow   (overflow),
    .zero       (zero),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference result: {overflow, result}, straight from the opcode definitions.
  function automatic logic [32:0] golden(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      r;
    logic [4:0]  sh;
    logic [63:0] w;
    logic [31:0] t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = b[4:0];
    case (o)
      4'd0: begin r = sa + sb; t = a + b;
              return {(r > 64'sd2147483647) || (r < -64'sd2147483648), t}; end
      4'd1: begin r = sa - sb; t = a - b;
              return {(r > 64'sd2147483647) || (r < -64'sd2147483648), t}; end
      4'd2: return {1'b0, a & b};
      4'd3: return {1'b0, a | b};
      4'd4: return {1'b0, a << sh};
      4'd5: begin w = {32'h0, a} << sh; return {1'b0, w[31:0] | w[63:32]}; end
      4'd6: return {1'b0, a >> sh};
      4'd7: begin t = $signed(a) >>> sh; return {1'b0, t}; end
      4'd8: return {1'b0, a ^ b};
      4'd9: begin w = {32'h0, a} * {32'h0, b}; return {|w[63:32], w[31:0]}; end
      default: return 33'd0;
    endcase
  endfunction

  // ---------------- reference model ----------------
  logic        m_valid;
  logic [31:0] m_res;
  logic        m_ovf;
  int          m_cd;      // multiply cycles remaining, 0 when idle
  logic [31:0] m_ma, m_mb;
  logic        m_ready;
  logic [32:0] g_in, g_mul;

  assign m_ready = (m_cd == 0) && (!m_valid || out_ready);
  assign g_in    = golden(op, src1, src2);
  assign g_mul   = golden(4'd9, m_ma, m_mb);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_res   <= 32'd0;
      m_ovf   <= 1'b0;
      m_cd    <= 0;
      m_ma    <= 32'd0;
      m_mb    <= 32'd0;
    end else if (m_cd != 0) begin
      m_cd <= m_cd - 1;
      if (m_cd == 1) begin
        m_valid <= 1'b1;
        m_res   <= g_mul[31:0];
        m_ovf   <= g_mul[32];
      end
    end else if (in_valid && m_ready && op == 4'd9) begin
      m_cd    <= 32;
      m_valid <= 1'b0;
      m_ma    <= src1;
      m_mb    <= src2;
    end else if (in_valid && m_ready) begin
      m_valid <= 1'b1;
      m_res   <= g_in[31:0];
      m_ovf   <= g_in[32];
    end else if (m_valid && out_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Compare DUT against the model every cycle, settled after the falling edge.
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      chk("m_busy", {31'd0, busy}, {31'd0, m_cd != 0});
      chk("m_in_ready", {31'd0, in_ready}, {31'd0, m_ready});
      chk("m_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      if (m_valid) begin
        chk("m_result", alu_result, m_res);
        chk("m_overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("m_zero", {31'd0, zero}, {31'd0, m_res == 32'd0});
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic [3:0]  v_op  [10];
  logic [31:0] v_a   [10];
  logic [31:0] v_b   [10];
  logic [31:0] v_exp [10];
  logic        v_ovf [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int nb;
    int seen;

    v_op[0] = 4'd0; v_a[0] = 32'h3;        v_b[0] = 32'h9;        v_exp[0] = 32'hC;        v_ovf[0] = 1'b0;
    v_op[1] = 4'd1; v_a[1] = 32'hCC;       v_b[1] = 32'hAA;       v_exp[1] = 32'h22;       v_ovf[1] = 1'b0;
    v_op[2] = 4'd5; v_a[2] = 32'h80000001; v_b[2] = 32'h4;        v_exp[2] = 32'h18;       v_ovf[2] = 1'b0;
    v_op[3] = 4'd7; v_a[3] = 32'h80000000; v_b[3] = 32'h4;        v_exp[3] = 32'hF8000000; v_ovf[3] = 1'b0;
    v_op[4] = 4'd2; v_a[4] = 32'hFF00FF00; v_b[4] = 32'h0F0F0F0F; v_exp[4] = 32'h0F000F00; v_ovf[4] = 1'b0;
    v_op[5] = 4'd3; v_a[5] = 32'hFF00FF00; v_b[5] = 32'h0F0F0F0F; v_exp[5] = 32'hFF0FFF0F; v_ovf[5] = 1'b0;
    v_op[6] = 4'd8; v_a[6] = 32'hFF00FF00; v_b[6] = 32'h0F0F0F0F; v_exp[6] = 32'hF00FF00F; v_ovf[6] = 1'b0;
    v_op[7] = 4'd4; v_a[7] = 32'h1;        v_b[7] = 32'h3F;       v_exp[7] = 32'h80000000; v_ovf[7] = 1'b0;
    v_op[8] = 4'd6; v_a[8] = 32'h80000000; v_b[8] = 32'h21;       v_exp[8] = 32'h40000000; v_ovf[8] = 1'b0;
    v_op[9] = 4'd1; v_a[9] = 32'h80000000; v_b[9] = 32'h1;        v_exp[9] = 32'h7FFFFFFF; v_ovf[9] = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_result", alu_result, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    // Signed overflow on ADD
    op = 4'd0; src1 = 32'h7FFFFFFF; src2 = 32'h1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("add_ovf_valid", {31'd0, out_valid}, 32'd1);
    chk("add_ovf_result", alu_result, 32'h80000000);
    chk("add_ovf_flag", {31'd0, overflow}, 32'd1);
    chk("add_ovf_zero", {31'd0, zero}, 32'd0);

    // Back-to-back single-cycle ops, one result per cycle
    for (int i = 0; i < 10; i++) begin
      op = v_op[i]; src1 = v_a[i]; src2 = v_b[i]; in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("b2b_result_%0d", i), alu_result, v_exp[i]);
      chk($sformatf("b2b_ovf_%0d", i), {31'd0, overflow}, {31'd0, v_ovf[i]});
      chk($sformatf("b2b_valid_%0d", i), {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    @(negedge clk);

    // Backpressure: hold 0xC for 5 cycles while a pending SUB waits
    op = 4'd0; src1 = 32'h3; src2 = 32'h9; in_valid = 1'b1;
    @(negedge clk);
    op = 4'd1; src1 = 32'h5; src2 = 32'h5; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_result", alu_result, 32'hC);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("drain_accept_valid", {31'd0, out_valid}, 32'd1);
    chk("drain_accept_result", alu_result, 32'h0);
    chk("drain_accept_zero", {31'd0, zero}, 32'd1);
    @(negedge clk);
    chk("drained_valid", {31'd0, out_valid}, 32'd0);

    // MUL 0x10000 * 0x10000: low half zero, high half nonzero
    op = 4'd9; src1 = 32'h10000; src2 = 32'h10000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0; nb = 0;
    if (busy) nb++;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
      if (busy) nb++;
    end
    chk("mul1_latency", n, 32);
    chk("mul1_busy_cycles", nb, 32);
    chk("mul1_result", alu_result, 32'h0);
    chk("mul1_ovf", {31'd0, overflow}, 32'd1);
    chk("mul1_zero", {31'd0, zero}, 32'd1);

    // MUL 3 * 7
    op = 4'd9; src1 = 32'h3; src2 = 32'h7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("mul2_latency", n, 32);
    chk("mul2_result", alu_result, 32'h15);
    chk("mul2_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);

    // Reset in the middle of a multiply
    op = 4'd9; src1 = 32'h1234; src2 = 32'h5678; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mulrst_busy", {31'd0, busy}, 32'd0);
    chk("mulrst_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mulrst_in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("mulrst_no_result", seen, 0);

    // Illegal opcode
    op = 4'hF; src1 = 32'hDEADBEEF; src2 = 32'h12345678; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("illegal_valid", {31'd0, out_valid}, 32'd1);
    chk("illegal_result", alu_result, 32'h0);
    chk("illegal_ovf", {31'd0, overflow}, 32'd0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
